// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the instruction memory handshake and loads the IF/ID register.
// Redirects squash in-flight fetches, and a one-entry skid buffer absorbs a word that lands during a stall.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcSrcId,
  input  logic [31:0] pcBranchId,
  input  logic [31:0] jumpAddress,
  input  logic        stallD,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [63:0] ifbus,
  output logic        ifValid
);

  typedef enum logic [1:0] {FETCH, DROP, HOLD} stateT;

  stateT       state;
  logic [31:0] pc;
  logic [31:0] savedTarget;
  logic [63:0] buffer;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pcPlus4;
  logic        fire;

  assign redirect = (pcSrcId != 2'b00) && !stallD;
  assign target   = (pcSrcId == 2'b01) ? pcBranchId : jumpAddress;
  assign pcPlus4  = pc + 32'd4;
  assign fire     = imemReq && imemReady;
  assign imemAddr = pc;

  // imemReq is registered and low for the first cycle after reset, so that cycle never completes a fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      savedTarget <= 32'h0;
      buffer      <= 64'h0;
      ifbus       <= 64'h0;
      ifValid     <= 1'b0;
      imemReq     <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          imemReq <= 1'b1;
          if (fire) begin
            if (redirect) begin
              pc      <= target;
              ifbus   <= 64'h0;
              ifValid <= 1'b0;
            end else if (!stallD) begin
              ifbus   <= {imemData, pcPlus4};
              ifValid <= 1'b1;
              pc      <= pcPlus4;
            end else begin
              buffer  <= {imemData, pcPlus4};
              pc      <= pcPlus4;
              state   <= HOLD;
              imemReq <= 1'b0;
            end
          end else if (redirect) begin
            ifbus   <= 64'h0;
            ifValid <= 1'b0;
            // An outstanding request must complete before the PC may move.
            if (imemReq) begin
              savedTarget <= target;
              state       <= DROP;
            end else begin
              pc <= target;
            end
          end else if (!stallD) begin
            ifbus   <= 64'h0;
            ifValid <= 1'b0;
          end
        end

        DROP: begin
          imemReq <= 1'b1;
          if (!stallD) begin
            ifbus   <= 64'h0;
            ifValid <= 1'b0;
          end
          if (redirect) begin
            savedTarget <= target;
          end
          if (fire) begin
            pc    <= redirect ? target : savedTarget;
            state <= FETCH;
          end
        end

        HOLD: begin
          if (!stallD) begin
            state   <= FETCH;
            imemReq <= 1'b1;
            if (redirect) begin
              pc      <= target;
              ifbus   <= 64'h0;
              ifValid <= 1'b0;
            end else begin
              ifbus   <= buffer;
              ifValid <= 1'b1;
            end
          end
        end

        default: begin
          state   <= FETCH;
          imemReq <= 1'b1;
        end
      endcase
    end
  end

endmodule
